// File: rtl/ibex_hpm_counter_bank_pkg.sv
// Shared constants, CSR numbers and types for the HPM counter bank.
package ibex_hpm_counter_bank_pkg;

  localparam int unsigned CsrAddrW    = 12;
  localparam int unsigned CsrDataW    = 32;
  localparam int unsigned PmcIdxW     = 5;
  localparam int unsigned PmcValW     = 64;
  localparam int unsigned HpmFirstIdx = 3;

  localparam int unsigned HPM_EV_IRQ_EN_BIT = 30;
  localparam int unsigned HPM_EV_EXP_EN_BIT = 31;

  typedef enum logic [11:0] {
    CSR_MCOUNTINHIBIT = 12'h320,
    CSR_MHPMEVENT3    = 12'h323,
    CSR_MHPMOVF       = 12'h7D8,
    CSR_MHPMCOUNTER3  = 12'hB03,
    CSR_MHPMCOUNTER3H = 12'hB83
  } csr_num_e;

  typedef enum logic [1:0] {
    EXP_IDLE,
    EXP_REQ,
    EXP_WFO
  } hpm_exp_state_e;

  // Counter snapshot handed to the external performance-monitor controller
  typedef struct packed {
    logic [PmcIdxW-1:0] idx;
    logic [PmcValW-1:0] val;
  } pmc_payload_t;

endpackage

// File: rtl/ibex_hpm_counter_bank_if.sv
// CSR port and export handshake between the CSR file / controller and the bank.
interface ibex_hpm_counter_bank_if;
  import ibex_hpm_counter_bank_pkg::*;

  logic                csr_access;
  logic                csr_we;
  logic [CsrAddrW-1:0] csr_addr;
  logic [CsrDataW-1:0] csr_wdata;
  logic [CsrDataW-1:0] csr_rdata;
  logic                ovf_irq;
  logic                pmc_req;
  logic                pmc_ack;
  logic [PmcIdxW-1:0]  pmc_idx;
  logic [PmcValW-1:0]  pmc_val;

  modport master (
    output csr_access, csr_we, csr_addr, csr_wdata, pmc_ack,
    input  csr_rdata, ovf_irq, pmc_req, pmc_idx, pmc_val
  );

  modport slave (
    input  csr_access, csr_we, csr_addr, csr_wdata, pmc_ack,
    output csr_rdata, ovf_irq, pmc_req, pmc_idx, pmc_val
  );

endinterface

// File: rtl/ibex_hpm_counter.sv
// One HPM counter: event mux, inhibit, LO/HI CSR write and wrap detection.
module ibex_hpm_counter
  import ibex_hpm_counter_bank_pkg::*;
#(
  parameter int unsigned CounterWidth = 48,
  parameter int unsigned NumEvents    = 16,
  parameter int unsigned EvSelW       = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumEvents-1:0]    events,
  input  logic [EvSelW-1:0]       sel,
  input  logic                    inhibit,
  input  logic                    wr_lo,
  input  logic                    wr_hi,
  input  logic [CsrDataW-1:0]     wdata,
  output logic [CounterWidth-1:0] count,
  output logic                    ovf_c
);

  localparam int unsigned HiW = CounterWidth - CsrDataW;

  logic ev_hit;
  logic inc;

  // Event 0 never counts; out-of-range selects are ignored
  assign ev_hit = (sel != '0) && (32'(sel) < NumEvents) && events[sel];
  assign inc    = ev_hit && !inhibit;
  // A CSR write suppresses both the increment and the wrap
  assign ovf_c  = inc && (&count) && !wr_lo && !wr_hi;

  // Counter register: CSR writes take priority over counting
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (wr_lo) begin
      count[CsrDataW-1:0] <= wdata;
    end else if (wr_hi) begin
      count[CounterWidth-1:CsrDataW] <= wdata[HiW-1:0];
    end else if (inc) begin
      count <= count + CounterWidth'(1);
    end
  end

endmodule

// File: rtl/ibex_hpm_counter_bank.sv
// Performance-monitor counter bank with CSR access, overflow IRQ and export handshake.
module ibex_hpm_counter_bank
  import ibex_hpm_counter_bank_pkg::*;
#(
  parameter int unsigned NumCounters  = 8,
  parameter int unsigned CounterWidth = 48,
  parameter int unsigned NumEvents    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumEvents-1:0] events_i,
  ibex_hpm_counter_bank_if.slave bus
);

  localparam int unsigned EvSelW = $clog2(NumEvents);

  logic                    csr_wr;
  logic [CounterWidth-1:0] count [NumCounters];
  logic [NumCounters-1:0]  ovf_set, wr_lo, wr_hi;
  logic [EvSelW-1:0]       ev_sel_q [NumCounters];
  logic [EvSelW-1:0]       ev_sel_d [NumCounters];
  logic [NumCounters-1:0]  irq_en_q, irq_en_d, exp_en_q, exp_en_d;
  logic [NumCounters-1:0]  inhibit_q, inhibit_d, pend_q, pend_d;
  logic [NumCounters-1:0]  w1c, exp_clr, cand;
  logic                    irq_q, irq_d;
  logic [CsrDataW-1:0]     rdata_c;
  hpm_exp_state_e          state_q, state_d;
  logic                    req_q, req_d;
  pmc_payload_t            pmc_q, pmc_d, pick;

  assign csr_wr = bus.csr_access & bus.csr_we;

  // Per-counter LO/HI write strobes
  always_comb begin : wr_decode
    for (int i = 0; i < NumCounters; i++) begin
      wr_lo[i] = csr_wr && (bus.csr_addr == 12'(CSR_MHPMCOUNTER3)  + 12'(i));
      wr_hi[i] = csr_wr && (bus.csr_addr == 12'(CSR_MHPMCOUNTER3H) + 12'(i));
    end
  end

  for (genvar g = 0; g < NumCounters; g++) begin : g_cnt
    ibex_hpm_counter #(
      .CounterWidth (CounterWidth),
      .NumEvents    (NumEvents),
      .EvSelW       (EvSelW)
    ) u_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .events  (events_i),
      .sel     (ev_sel_q[g]),
      .inhibit (inhibit_q[g]),
      .wr_lo   (wr_lo[g]),
      .wr_hi   (wr_hi[g]),
      .wdata   (bus.csr_wdata),
      .count   (count[g]),
      .ovf_c   (ovf_set[g])
    );
  end

  // Next state of config registers and overflow status; a new wrap beats any clear
  always_comb begin : csr_next
    inhibit_d = inhibit_q;
    irq_en_d  = irq_en_q;
    exp_en_d  = exp_en_q;
    w1c       = '0;
    for (int i = 0; i < NumCounters; i++) begin
      ev_sel_d[i] = ev_sel_q[i];
    end
    if (csr_wr && (bus.csr_addr == 12'(CSR_MCOUNTINHIBIT))) begin
      inhibit_d = bus.csr_wdata[HpmFirstIdx +: NumCounters];
    end
    if (csr_wr && (bus.csr_addr == 12'(CSR_MHPMOVF))) begin
      w1c = bus.csr_wdata[HpmFirstIdx +: NumCounters];
    end
    for (int i = 0; i < NumCounters; i++) begin
      if (csr_wr && (bus.csr_addr == 12'(CSR_MHPMEVENT3) + 12'(i))) begin
        ev_sel_d[i] = bus.csr_wdata[EvSelW-1:0];
        irq_en_d[i] = bus.csr_wdata[HPM_EV_IRQ_EN_BIT];
        exp_en_d[i] = bus.csr_wdata[HPM_EV_EXP_EN_BIT];
      end
    end
    pend_d = ovf_set | (pend_q & ~w1c & ~exp_clr);
    irq_d  = |(pend_d & irq_en_d);
  end

  // Config, status and interrupt registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inhibit_q <= '0;
      irq_en_q  <= '0;
      exp_en_q  <= '0;
      pend_q    <= '0;
      irq_q     <= 1'b0;
      for (int i = 0; i < NumCounters; i++) ev_sel_q[i] <= '0;
    end else begin
      inhibit_q <= inhibit_d;
      irq_en_q  <= irq_en_d;
      exp_en_q  <= exp_en_d;
      pend_q    <= pend_d;
      irq_q     <= irq_d;
      for (int i = 0; i < NumCounters; i++) ev_sel_q[i] <= ev_sel_d[i];
    end
  end

  // Export FSM state and registered handshake outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EXP_IDLE;
      req_q   <= 1'b0;
      pmc_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pmc_q   <= pmc_d;
    end
  end

  // Export FSM next state: lowest pending exportable counter wins
  always_comb begin : exp_next
    state_d = state_q;
    pmc_d   = pmc_q;
    exp_clr = '0;
    pick    = '0;
    cand    = pend_q & exp_en_q;
    for (int i = NumCounters - 1; i >= 0; i--) begin
      if (cand[i]) begin
        pick.idx = 5'(HpmFirstIdx + i);
        pick.val = 64'(count[i]);
      end
    end
    case (state_q)
      EXP_IDLE: begin
        if (|cand) begin
          state_d = EXP_REQ;
          pmc_d   = pick;
        end
      end
      EXP_REQ: begin
        if (bus.pmc_ack) begin
          state_d = EXP_WFO;
          for (int i = 0; i < NumCounters; i++) begin
            exp_clr[i] = (pmc_q.idx == 5'(HpmFirstIdx + i));
          end
        end
      end
      EXP_WFO: begin
        if (!bus.pmc_ack) state_d = EXP_IDLE;
      end
      default: state_d = EXP_IDLE;
    endcase
    req_d = (state_d == EXP_REQ);
  end

  // CSR read mux; unmapped addresses read zero
  always_comb begin : rd_mux
    rdata_c = '0;
    if (bus.csr_access) begin
      if (bus.csr_addr == 12'(CSR_MCOUNTINHIBIT)) rdata_c = 32'({inhibit_q, 3'b000});
      if (bus.csr_addr == 12'(CSR_MHPMOVF))       rdata_c = 32'({pend_q, 3'b000});
      for (int i = 0; i < NumCounters; i++) begin
        if (bus.csr_addr == 12'(CSR_MHPMEVENT3) + 12'(i)) begin
          rdata_c                    = 32'(ev_sel_q[i]);
          rdata_c[HPM_EV_IRQ_EN_BIT] = irq_en_q[i];
          rdata_c[HPM_EV_EXP_EN_BIT] = exp_en_q[i];
        end
        if (bus.csr_addr == 12'(CSR_MHPMCOUNTER3) + 12'(i)) begin
          rdata_c = count[i][CsrDataW-1:0];
        end
        if (bus.csr_addr == 12'(CSR_MHPMCOUNTER3H) + 12'(i)) begin
          rdata_c = 32'(count[i][CounterWidth-1:CsrDataW]);
        end
      end
    end
  end

  assign bus.csr_rdata = rdata_c;
  assign bus.ovf_irq   = irq_q;
  assign bus.pmc_req   = req_q;
  assign bus.pmc_idx   = pmc_q.idx;
  assign bus.pmc_val   = pmc_q.val;

endmodule
